// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (I-cache / D-cache) arbiter onto one physical-memory port.
// Optional ARB_ROUND_ROBIN_EN swaps fixed data priority for last-grant round robin on ties.
`default_nettype none

module mem_arbiter (
    input  logic         clk,
    input  logic         reset_n,

    input  logic         i_read,
    input  logic [15:0]  i_address,
    output logic         i_resp,
    output logic [127:0] i_rdata,

    input  logic         d_read,
    input  logic         d_write,
    input  logic [15:0]  d_address,
    input  logic [127:0] d_wdata,
    output logic         d_resp,
    output logic [127:0] d_rdata,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,

    output logic [7:0]   i_grant_count_o,
    output logic [7:0]   d_grant_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t         state_q;
    logic [15:0]    addr_q;
    logic [127:0]   wdata_q;
    logic           rd_q;
    logic           wr_q;
    logic [7:0]     i_cnt_q;
    logic [7:0]     d_cnt_q;

    logic           data_req;
    logic           pick_data;

    assign data_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data port was served last; on a tie the other port wins.
    logic           last_d_q;
    assign pick_data = data_req & (~i_read | ~last_d_q);
`else
    assign pick_data = data_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            i_cnt_q  <= '0;
            d_cnt_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_data) begin
                        state_q <= SERVE_D;
                        addr_q  <= d_address;
                        wdata_q <= d_wdata;
                        // Simultaneous read+write is treated as a write.
                        wr_q    <= d_write;
                        rd_q    <= ~d_write;
                    end else if (i_read) begin
                        state_q <= SERVE_I;
                        addr_q  <= i_address;
                        wdata_q <= '0;
                        wr_q    <= 1'b0;
                        rd_q    <= 1'b1;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state_q  <= IDLE;
                        rd_q     <= 1'b0;
                        wr_q     <= 1'b0;
                        i_cnt_q  <= i_cnt_q + 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q <= 1'b0;
`endif
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state_q  <= IDLE;
                        rd_q     <= 1'b0;
                        wr_q     <= 1'b0;
                        d_cnt_q  <= d_cnt_q + 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read       = rd_q;
    assign pmem_write      = wr_q;
    assign pmem_address    = addr_q;
    assign pmem_wdata      = wdata_q;

    // Completion is combinational so the port sees data in the pmem_resp cycle.
    assign i_resp          = (state_q == SERVE_I) & pmem_resp;
    assign d_resp          = (state_q == SERVE_D) & pmem_resp;
    assign i_rdata         = reset_n ? pmem_rdata : '0;
    assign d_rdata         = reset_n ? pmem_rdata : '0;

    assign i_grant_count_o = i_cnt_q;
    assign d_grant_count_o = d_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_read = 1'b0;
    logic [15:0]  i_address = '0;
    logic         i_resp;
    logic [127:0] i_rdata;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [15:0]  d_address = '0;
    logic [127:0] d_wdata = '0;
    logic         d_resp;
    logic [127:0] d_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [7:0]   i_cnt;
    logic [7:0]   d_cnt;

    int           n_assert = 0;
    int           n_fail = 0;
    logic [7:0]   exp_i = '0;
    logic [7:0]   exp_d = '0;
    bit           rr_second_d;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_0F = {16{8'h0F}};
    localparam logic [127:0] PAT_3C = {16{8'h3C}};

    mem_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_read          (i_read),
        .i_address       (i_address),
        .i_resp          (i_resp),
        .i_rdata         (i_rdata),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_address       (d_address),
        .d_wdata         (d_wdata),
        .d_resp          (d_resp),
        .d_rdata         (d_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp),
        .i_grant_count_o (i_cnt),
        .d_grant_count_o (d_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_assert++;
        if (obs !== want) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Runs one granted transaction; the request is already presented in the current IDLE cycle.
    task automatic serve(input bit is_d, input bit exp_wr, input logic [15:0] exp_addr,
                         input logic [127:0] exp_wdata, input int lat,
                         input logic [127:0] rdata, input bit drop);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            pmem_resp  = (k == lat - 1);
            pmem_rdata = (k == lat - 1) ? rdata : ~rdata;
            if (is_d) begin
                d_address = d_address + 16'h1000;
                d_wdata   = ~d_wdata;
            end else begin
                i_address = i_address + 16'h0010;
            end
            #1;
            check("pmem_read", pmem_read, !exp_wr);
            check("pmem_write", pmem_write, exp_wr);
            check("pmem_address", pmem_address, exp_addr);
            if (exp_wr) check("pmem_wdata", pmem_wdata, exp_wdata);
            check("i_resp", i_resp, (!is_d) && (k == lat - 1));
            check("d_resp", d_resp, is_d && (k == lat - 1));
            if (k == lat - 1) begin
                if (is_d) check("d_rdata", d_rdata, rdata);
                else      check("i_rdata", i_rdata, rdata);
            end
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        if (drop) begin
            if (is_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read  = 1'b0;
            end
        end
        if (is_d) exp_d_inc();
        else      exp_i_inc();
        #1;
        check("idle_pmem_read", pmem_read, 1'b0);
        check("idle_pmem_write", pmem_write, 1'b0);
        check("idle_i_resp", i_resp, 1'b0);
        check("idle_d_resp", d_resp, 1'b0);
        check("i_grant_count", i_cnt, exp_i);
        check("d_grant_count", d_cnt, exp_d);
    endtask

    function automatic void exp_i_inc();
        exp_i = exp_i + 8'd1;
    endfunction

    function automatic void exp_d_inc();
        exp_d = exp_d + 8'd1;
    endfunction

    initial begin
        // Reset state, with memory data present to show rdata is forced low.
        pmem_rdata = PAT_3C;
        #2;
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_i_resp", i_resp, 1'b0);
        check("rst_d_resp", d_resp, 1'b0);
        check("rst_i_rdata", i_rdata, 128'h0);
        check("rst_d_rdata", d_rdata, 128'h0);
        check("rst_pmem_address", pmem_address, 16'h0);
        check("rst_i_cnt", i_cnt, 8'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Collision straight after reset: D wins first in both builds.
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h0100;
        d_read = 1'b1; d_address = 16'h0200;
        #1;
        check("coll_idle_read", pmem_read, 1'b0);
        serve(1'b1, 1'b0, 16'h0200, '0, 2, PAT_A5, 1'b0);
        d_address = 16'h0200;
`ifdef ARB_ROUND_ROBIN_EN
        serve(1'b0, 1'b0, 16'h0100, '0, 2, PAT_0F, 1'b0);
        i_address = 16'h0100;
        rr_second_d = 1'b1;
`else
        serve(1'b1, 1'b0, 16'h0200, '0, 2, PAT_0F, 1'b0);
        d_address = 16'h0200;
        rr_second_d = 1'b0;
`endif
        serve(1'b1, 1'b0, 16'h0200, '0, 1, PAT_3C, 1'b1);
        if (rr_second_d) begin
            i_read = 1'b1; i_address = 16'h0100;
        end
        serve(1'b0, 1'b0, 16'h0100, '0, 1, PAT_A5, 1'b1);

        // Single I fetch, memory answers on the third command cycle; request dropped early.
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h1230;
        #1;
        check("ifetch_idle_read", pmem_read, 1'b0);
        @(negedge clk);
        i_read = 1'b0; i_address = 16'h1230;
        serve(1'b0, 1'b0, 16'h1230, '0, 2, PAT_A5, 1'b1);

        // D write with the address moving mid-transaction (0x4000 -> 0x5000).
        d_write = 1'b1; d_address = 16'h4000; d_wdata = PAT_0F;
        serve(1'b1, 1'b1, 16'h4000, PAT_0F, 3, PAT_3C, 1'b1);

        // Read and write together is a write.
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h6000; d_wdata = PAT_3C;
        serve(1'b1, 1'b1, 16'h6000, PAT_3C, 2, PAT_0F, 1'b1);

        // pmem_resp while idle is ignored.
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = PAT_A5;
        #1;
        check("idle_resp_i", i_resp, 1'b0);
        check("idle_resp_d", d_resp, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        check("idle_resp_cmd", pmem_read, 1'b0);
        check("idle_resp_icnt", i_cnt, exp_i);

        // Back-to-back minimum-latency I fetches; the count crosses 255 -> 0.
        for (int k = 0; k < 256; k++) begin
            i_read = 1'b1; i_address = 16'(k * 16);
            serve(1'b0, 1'b0, 16'(k * 16), '0, 1, {8{16'(k)}}, 1'b1);
        end
        check("wrap_i_cnt", i_cnt, exp_i);

        // Reset during SERVE_I; stale pmem_resp after release gives no i_resp.
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h1230;
        @(negedge clk);
        #1;
        check("mr_pmem_read_before", pmem_read, 1'b1);
        #1;
        reset_n = 1'b0;
        pmem_rdata = PAT_A5;
        #1;
        check("mr_pmem_read_async", pmem_read, 1'b0);
        check("mr_pmem_address", pmem_address, 16'h0);
        check("mr_i_rdata", i_rdata, 128'h0);
        i_read = 1'b0;
        exp_i = '0;
        exp_d = '0;
        @(negedge clk);
        reset_n = 1'b1;
        pmem_resp = 1'b1;
        #1;
        check("mr_stale_i_resp", i_resp, 1'b0);
        @(negedge clk);
        #1;
        check("mr_stale_i_resp2", i_resp, 1'b0);
        check("mr_stale_cmd", pmem_read, 1'b0);
        check("mr_i_cnt", i_cnt, 8'h0);
        pmem_resp = 1'b0;
        d_read = 1'b1; d_address = 16'h2220;
        serve(1'b1, 1'b0, 16'h2220, '0, 2, PAT_0F, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
